// File: rtl/array_unpacker.sv
// Array unpacker: captures one flattened array and streams its elements out.
// Define UNPACK_REVERSE_EN to emit elements last-to-first.
module array_unpacker #(
   parameter int DATA_W  = 4,
   parameter int MAX_LEN = 4,
   parameter int LEN_W   = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LEN_W-1:0]          in_len,
   input  logic [MAX_LEN*DATA_W-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [LEN_W-1:0]          out_idx,
   output logic                      out_last,
   output logic                      len_err
);

   typedef enum logic {IDLE, STREAM} state_e;

   state_e                    state_q, state_d;
   logic [MAX_LEN*DATA_W-1:0] buf_q, buf_d;
   logic [LEN_W-1:0]          end_q, end_d;
   logic [LEN_W-1:0]          idx_q, idx_d;
   logic [DATA_W-1:0]         data_q, data_d;
   logic                      last_q, last_d;
   logic                      err_q, err_d;

   logic                      len_ok;
   logic [LEN_W-1:0]          first_idx;
   logic [LEN_W-1:0]          final_idx;
   logic [LEN_W-1:0]          next_idx;

   function automatic logic [DATA_W-1:0] elem(
      input logic [MAX_LEN*DATA_W-1:0] v,
      input logic [LEN_W-1:0]          i
   );
      logic [DATA_W-1:0] r;
      r = '0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (i == LEN_W'(k)) r = v[k*DATA_W +: DATA_W];
      end
      return r;
   endfunction

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == STREAM);
   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
   assign len_err   = err_q;

   assign len_ok = (in_len != '0) && (in_len <= LEN_W'(MAX_LEN));

   // end_q holds the index of the beat that closes the array
`ifdef UNPACK_REVERSE_EN
   assign first_idx = in_len - LEN_W'(1);
   assign final_idx = '0;
   assign next_idx  = idx_q - LEN_W'(1);
`else
   assign first_idx = '0;
   assign final_idx = in_len - LEN_W'(1);
   assign next_idx  = idx_q + LEN_W'(1);
`endif

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      end_d   = end_q;
      idx_d   = idx_q;
      data_d  = data_q;
      last_d  = last_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (len_ok) begin
                  state_d = STREAM;
                  buf_d   = in_data;
                  end_d   = final_idx;
                  idx_d   = first_idx;
                  data_d  = elem(in_data, first_idx);
                  last_d  = (first_idx == final_idx);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (last_q) begin
                  state_d = IDLE;
                  last_d  = 1'b0;
               end else begin
                  idx_d  = next_idx;
                  data_d = elem(buf_q, next_idx);
                  last_d = (next_idx == end_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         end_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         end_q   <= end_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_array_unpacker.sv
// Bench for array_unpacker: directed cases plus randomized arrays and stalls.
// Expected beats come from an ordered list of elements built per array.
module tb_array_unpacker;

   localparam int DATA_W  = 4;
   localparam int MAX_LEN = 4;
   localparam int LEN_W   = 3;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic [LEN_W-1:0]          in_len;
   logic [MAX_LEN*DATA_W-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [LEN_W-1:0]          out_idx;
   logic                      out_last;
   logic                      len_err;

   int checks = 0;
   int errors = 0;

   array_unpacker #(
      .DATA_W (DATA_W),
      .MAX_LEN(MAX_LEN),
      .LEN_W  (LEN_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_len   (in_len),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_idx  (out_idx),
      .out_last (out_last),
      .len_err  (len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Order in which element positions leave the block, beat by beat
   function automatic int pos_of_beat(input int k, input int len);
`ifdef UNPACK_REVERSE_EN
      return len - 1 - k;
`else
      return k;
`endif
   endfunction

   // Offer an array and follow it to completion. stall_pct: chance of
   // out_ready low per cycle. abort_after >= 0 asserts rst after that
   // many beats have been accepted.
   task automatic run_array(input int len, input logic [15:0] data,
                            input int stall_pct, input int abort_after);
      int          exp_q[$];
      int          pos_q[$];
      int          k;
      int          cyc;
      logic        rdy;
      for (int b = 0; b < len; b++) begin
         pos_q.push_back(pos_of_beat(b, len));
         exp_q.push_back((data >> (4 * pos_of_beat(b, len))) & 16'hF);
      end
      chk("pre_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_len   = LEN_W'(len);
      in_data  = data;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      k   = 0;
      cyc = 0;
      while (k < len && cyc < 200) begin
         if (abort_after >= 0 && k == abort_after) begin
            out_ready = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready_hi", in_ready, 0);
            rst = 1'b0;
            #1;
            chk("rst_in_ready", in_ready, 1);
            @(negedge clk);
            chk("post_rst_valid", out_valid, 0);
            return;
         end
         chk("beat_valid", out_valid, 1);
         chk("beat_data", out_data, exp_q[k]);
         chk("beat_idx", out_idx, pos_q[k]);
         chk("beat_last", out_last, (k == len - 1));
         chk("busy_in_ready", in_ready, 0);
         rdy = ($urandom_range(99) >= stall_pct);
         out_ready = rdy;
         in_data   = 16'($urandom);
         @(negedge clk);
         if (rdy) k++;
         cyc++;
      end
      chk("stream_timeout", (cyc < 200), 1);
      out_ready = 1'b0;
      chk("end_out_valid", out_valid, 0);
      chk("end_in_ready", in_ready, 1);
      chk("end_len_err", len_err, 0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_len    = '0;
      in_data   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_len_err", len_err, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      run_array(4, 16'h4321, 0, -1);
      run_array(1, 16'h0004, 0, -1);
      run_array(1, 16'h0009, 0, -1);
      run_array(3, 16'h0241, 40, -1);

      in_valid = 1'b1;
      in_len   = 3'd0;
      in_data  = 16'h1234;
      @(negedge clk);
      chk("err0_pulse", len_err, 1);
      chk("err0_valid", out_valid, 0);
      chk("err0_in_ready", in_ready, 1);
      in_len = 3'd5;
      @(negedge clk);
      chk("err5_pulse", len_err, 1);
      chk("err5_valid", out_valid, 0);
      chk("err5_in_ready", in_ready, 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("err_clear", len_err, 0);
      chk("err_idle_valid", out_valid, 0);

      run_array(4, 16'h4321, 0, 2);
      run_array(2, 16'h0087, 0, -1);
      run_array(3, 16'h0321, 0, -1);

      for (int n = 0; n < 25; n++) begin
         run_array(int'($urandom_range(MAX_LEN, 1)), 16'($urandom),
                   int'($urandom_range(60)), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
